scale_nx: RTL and testbench
===========================

// Module: scale_nx
// PURPOSE
//  Parametrised integer pixel scaler; successor to the fixed 2x line doubler in the video path.
//  Captures one input line into a ping-pong line buffer and replays it SCALE times
//  horizontally and vertically, with selectable nearest / scanline / smoothing output modes.
//  Channel count and depth are generic. Sits between the core video output and the
//  output timing generator; the input and output sides run on independent clock enables.
// PARAMETERS
//  LENGTH     1024  max input pixels per line (buffer depth, power of two)
//  CHANNELS   3     colour channels per pixel
//  CDEPTH     8     bits per channel; PW = CHANNELS*CDEPTH
//  SCALE_MAX  4     largest scale factor supported (>=2); YW = $clog2(SCALE_MAX)
// PORTS
//  clk          in   1    system clock
//  reset        in   1    synchronous, active-high reset
//  ce_in        in   1    input pixel enable
//  pixel_in     in   PW   input pixel, channel 0 in LSBs
//  reset_line   in   1    high during input hblank; falling edge = new input line
//  reset_frame  in   1    high during input vblank; falling edge = new input frame
//  scale        in   3    requested scale factor (1..SCALE_MAX)
//  mode         in   2    0 nearest, 1 scanline 50%, 2 scanline 75%, 3 horizontal smooth
//  ce_out       in   1    output pixel enable
//  read_y       in   YW   output sub-row within the scaled line (0..scale-1)
//  hblank       in   1    output horizontal blank
//  pixel_out    out  PW   scaled output pixel
//  overflow     out  1    sticky: input line exceeded LENGTH pixels
// BEHAVIOUR
//  Reset: pixel_out=0, overflow=0, all counters 0, write buffer 0, line_valid=0.
//  Input side, on ce_in only:
//   - reset_line/reset_frame registered on ce_in; edges detected on the registered copy.
//   - while wr_addr<LENGTH: write pixel_in at wr_addr, wr_addr++; past that, drop the pixel, set overflow.
//   - reset_line falling edge: swap buffers, latch line_width=wr_addr, wr_addr=0, line_valid=1.
//   - reset_frame falling edge: additionally clears overflow. A line-swap on the same ce_in still occurs.
//  Output side, on ce_out only:
//   - eff_scale = clamp(scale, 1, SCALE_MAX), with 0 treated as 1; sampled only while hblank=1
//     and held constant across the active line.
//   - hblank=1: hphase=0, rd_addr=0, prev_pix=0.
//   - hblank=0: hphase++; on hphase==eff_scale-1, hphase=0 and rd_addr++ (saturates at LENGTH-1).
//   - read from the buffer not being written; rd_addr>=line_width or line_valid=0 -> pixel 0.
//   - latency: pixel_out reflects rd_addr/hphase from 2 ce_out cycles earlier (RAM read + output reg).
//  Mode arithmetic, per channel, CDEPTH-bit, truncating:
//   - 0: c.   1: c>>1 when read_y==eff_scale-1, else c.   2: (c>>1)+(c>>2) on that same row, else c.
//   - 3: hphase 0 of a source pixel with rd_addr>0 -> (c+prev)>>1, using a CDEPTH+1-bit sum;
//     otherwise c. prev_pix = the previous source pixel.
//   - eff_scale==1: scanline modes have no effect, because read_y==0 is treated as not last row
//     at scale 1.
//  Simultaneous ce_in and ce_out: both sides are serviced in the same cycle; ping-pong prevents
//  any RAM address conflict. A mode change takes effect on the next ce_out.
//  Reset mid-line: buffer contents are not cleared, but line_valid=0 forces black until the next
//  line swap.
// TESTING
//  1. Reset, then no input line -> pixel_out==0 for a full output line at every scale.
//  2. Input line 0x000001..0x000008, scale=2, mode 0 -> output 01,01,02,02,...,08,08, then 0.
//  3. Same line, scale=3, mode=1, read_y=2 -> each pixel emitted 3x, channel value halved
//     (0x10 -> 0x08); read_y=0 unhalved.
//  4. mode=3, scale=2, pixels 0x20 and 0x40 -> output 0x20,0x20,0x30,0x40.
//  5. LENGTH+5 input pixels -> overflow=1, first LENGTH pixels replayed; cleared by the
//     reset_frame falling edge.
//  6. ce_in and ce_out every cycle, scale=4 written mid-line -> factor changes only after
//     the next hblank; no corruption.

Source files
------------

// File: rtl/scale_nx.sv
// scale_nx: parametrised integer pixel scaler.
//   Captures one input line into a ping-pong line buffer, then replays it
//   eff_scale times horizontally (and, via i_read_y, vertically) with
//   nearest, scanline 50%, scanline 75% or horizontal smoothing output.
//   The input and output sides advance on independent clock enables.
// Ports:
//   i_clk, i_reset       system clock, synchronous active-high reset
//   i_ce_in              input pixel enable
//   i_pixel_in  [PW]     input pixel, channel 0 in the LSBs
//   i_reset_line         input hblank; its falling edge starts a new line
//   i_reset_frame        input vblank; its falling edge clears o_overflow
//   i_scale     [3]      requested scale factor, clamped to 1..SCALE_MAX
//   i_mode      [2]      0 nearest, 1 scanline 50%, 2 scanline 75%, 3 smooth
//   i_ce_out             output pixel enable
//   i_read_y    [YW]     output sub-row within the scaled line
//   i_hblank             output horizontal blank
//   o_pixel_out [PW]     scaled pixel, two ce_out cycles after its address
//   o_overflow           sticky: an input line exceeded LENGTH pixels
module scale_nx #(
  parameter  int LENGTH    = 1024,
  parameter  int CHANNELS  = 3,
  parameter  int CDEPTH    = 8,
  parameter  int SCALE_MAX = 4,
  localparam int PW        = CHANNELS * CDEPTH,
  localparam int YW        = $clog2(SCALE_MAX)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce_in,
  input  logic [PW-1:0] i_pixel_in,
  input  logic          i_reset_line,
  input  logic          i_reset_frame,
  input  logic [2:0]    i_scale,
  input  logic [1:0]    i_mode,
  input  logic          i_ce_out,
  input  logic [YW-1:0] i_read_y,
  input  logic          i_hblank,
  output logic [PW-1:0] o_pixel_out,
  output logic          o_overflow
);

  localparam int              AW       = $clog2(LENGTH);
  localparam int              SW       = $clog2(SCALE_MAX + 1);
  localparam logic [AW:0]     LEN_W    = (AW + 1)'(LENGTH);
  localparam logic [AW-1:0]   ADDR_MAX = AW'(LENGTH - 1);
  localparam logic [SW-1:0]   SMAX     = SW'(SCALE_MAX);

  // Clamp the requested factor into 1..SCALE_MAX (0 behaves as 1).
  function automatic logic [SW-1:0] clamp_scale(input logic [2:0] s);
    if (s == 3'd0) begin
      return SW'(1);
    end else if (int'(s) > SCALE_MAX) begin
      return SMAX;
    end else begin
      return SW'(s);
    end
  endfunction

  // Per-channel output arithmetic; all results truncate to CDEPTH bits.
  function automatic logic [PW-1:0] shade_pixel(
    input logic [PW-1:0] cur,
    input logic [PW-1:0] prev,
    input logic [1:0]    mode,
    input logic          smooth,
    input logic          shade_row
  );
    logic [PW-1:0]     res;
    logic [CDEPTH-1:0] c;
    logic [CDEPTH-1:0] p;
    res = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = cur[i*CDEPTH +: CDEPTH];
      p = prev[i*CDEPTH +: CDEPTH];
      case (mode)
        2'd0:    res[i*CDEPTH +: CDEPTH] = c;
        2'd1:    res[i*CDEPTH +: CDEPTH] = shade_row ? (c >> 1'b1) : c;
        2'd2:    res[i*CDEPTH +: CDEPTH] = shade_row ? ((c >> 1'b1) + (c >> 2'd2)) : c;
        2'd3:    res[i*CDEPTH +: CDEPTH] = smooth ? CDEPTH'(({1'b0, c} + {1'b0, p}) >> 1'b1) : c;
        default: res[i*CDEPTH +: CDEPTH] = c;
      endcase
    end
    return res;
  endfunction

  // Two line halves; bit AW of the address selects the half.
  logic [PW-1:0] r_mem [0:2*LENGTH-1];

  // Input side state
  logic          r_line_q;
  logic          r_frame_q;
  logic          r_wbuf;
  logic [AW:0]   r_wr_addr;
  logic [AW:0]   r_line_width;
  logic          r_line_valid;
  logic          r_overflow;

  // Output side state
  logic [SW-1:0] r_eff_scale;
  logic [YW-1:0] r_hphase;
  logic [AW-1:0] r_rd_addr;
  logic [PW-1:0] r_rd_data;
  logic          r_s1_smooth;
  logic          r_s1_last;
  logic [PW-1:0] r_prev_pix;
  logic [PW-1:0] r_pixel_out;

  logic w_line_fall;
  logic w_frame_fall;
  logic w_wr_room;
  logic w_last_phase;
  logic w_rd_ok;
  logic w_shade_row;

  // Edges compare the live level with the copy registered on the last ce_in.
  assign w_line_fall  = r_line_q & ~i_reset_line;
  assign w_frame_fall = r_frame_q & ~i_reset_frame;
  assign w_wr_room    = (r_wr_addr < LEN_W);

  assign w_last_phase = (SW'(r_hphase) == (r_eff_scale - SW'(1)));
  assign w_rd_ok      = r_line_valid && ({1'b0, r_rd_addr} < r_line_width);
  // At scale 1 row 0 is never the "last" row, so scanline modes pass through.
  assign w_shade_row  = (r_eff_scale != SW'(1)) && (SW'(i_read_y) == (r_eff_scale - SW'(1)));

  // Line buffer write port; no reset so the array can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_ce_in && !w_line_fall && w_wr_room) begin
      r_mem[{r_wbuf, r_wr_addr[AW-1:0]}] <= i_pixel_in;
    end
  end

  // Input sequencing: write pointer, buffer swap, overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_line_q     <= 1'b0;
      r_frame_q    <= 1'b0;
      r_wbuf       <= 1'b0;
      r_wr_addr    <= '0;
      r_line_width <= '0;
      r_line_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (i_ce_in) begin
      r_line_q  <= i_reset_line;
      r_frame_q <= i_reset_frame;
      if (w_line_fall) begin
        r_wbuf       <= ~r_wbuf;
        r_line_width <= r_wr_addr;
        r_wr_addr    <= '0;
        r_line_valid <= 1'b1;
      end else if (w_wr_room) begin
        r_wr_addr <= r_wr_addr + (AW + 1)'(1);
      end
      // A frame start wins over a pixel dropped on the same enable.
      if (w_frame_fall) begin
        r_overflow <= 1'b0;
      end else if (!w_line_fall && !w_wr_room) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output pipeline: address/phase counters, RAM read stage, output stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Scale resets to 1 so the phase counter wraps sensibly before any hblank.
      r_eff_scale <= SW'(1);
      r_hphase    <= '0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
      r_s1_smooth <= 1'b0;
      r_s1_last   <= 1'b0;
      r_prev_pix  <= '0;
      r_pixel_out <= '0;
    end else if (i_ce_out) begin
      r_rd_data   <= w_rd_ok ? r_mem[{~r_wbuf, r_rd_addr}] : '0;
      r_s1_smooth <= (r_hphase == '0) && (r_rd_addr != '0);
      r_s1_last   <= w_last_phase;
      if (i_hblank) begin
        r_eff_scale <= clamp_scale(i_scale);
        r_hphase    <= '0;
        r_rd_addr   <= '0;
        r_prev_pix  <= '0;
      end else begin
        if (w_last_phase) begin
          r_hphase <= '0;
          if (r_rd_addr != ADDR_MAX) begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end else begin
          r_hphase <= r_hphase + YW'(1);
        end
        // The last replica of a source pixel becomes "previous" for the next one.
        if (r_s1_last) begin
          r_prev_pix <= r_rd_data;
        end
      end
      r_pixel_out <= shade_pixel(r_rd_data, r_prev_pix, i_mode, r_s1_smooth, w_shade_row);
    end
  end

  assign o_pixel_out = r_pixel_out;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_scale_nx.sv
module tb_scale_nx;
  localparam int LENGTH    = 64;
  localparam int CHANNELS  = 3;
  localparam int CDEPTH    = 8;
  localparam int SCALE_MAX = 4;
  localparam int PW        = CHANNELS * CDEPTH;
  localparam int YW        = $clog2(SCALE_MAX);

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ce_in = 1'b0;
  logic [PW-1:0] i_pixel_in = '0;
  logic          i_reset_line = 1'b0;
  logic          i_reset_frame = 1'b0;
  logic [2:0]    i_scale = 3'd1;
  logic [1:0]    i_mode = 2'd0;
  logic          i_ce_out = 1'b0;
  logic [YW-1:0] i_read_y = '0;
  logic          i_hblank = 1'b1;
  logic [PW-1:0] o_pixel_out;
  logic          o_overflow;

  always #5 clk = ~clk;

  scale_nx #(.LENGTH(LENGTH), .CHANNELS(CHANNELS), .CDEPTH(CDEPTH), .SCALE_MAX(SCALE_MAX)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce_in(i_ce_in), .i_pixel_in(i_pixel_in),
    .i_reset_line(i_reset_line), .i_reset_frame(i_reset_frame), .i_scale(i_scale),
    .i_mode(i_mode), .i_ce_out(i_ce_out), .i_read_y(i_read_y), .i_hblank(i_hblank),
    .o_pixel_out(o_pixel_out), .o_overflow(o_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the line being captured, the line on display, and
  // the pending output expectation (output lags its source by one ce_out).
  logic [PW-1:0] m_cur[$];
  logic [PW-1:0] m_line [LENGTH];
  int            m_width;
  bit            m_valid, m_ovf, m_rl_prev, m_rf_prev;
  int            m_eff, m_k;
  bit            p_valid, p_sm;
  logic [PW-1:0] p_c, p_p;
  bit            exp_valid;
  logic [PW-1:0] exp_pix;

  function automatic int clamp_scale(int s);
    if (s == 0) return 1;
    if (s > SCALE_MAX) return SCALE_MAX;
    return s;
  endfunction

  function automatic logic [PW-1:0] src(int a);
    if (!m_valid || a >= m_width) return '0;
    return m_line[a];
  endfunction

  function automatic logic [PW-1:0] apply_mode(logic [PW-1:0] c, logic [PW-1:0] p, bit sm, int mode, int ry, int s);
    logic [PW-1:0] r;
    int cv, pv, ov;
    bit last;
    last = (s > 1) && (ry == s - 1);
    r = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cv = int'(c[ch*CDEPTH +: CDEPTH]);
      pv = int'(p[ch*CDEPTH +: CDEPTH]);
      case (mode)
        0: ov = cv;
        1: ov = last ? cv / 2 : cv;
        2: ov = last ? (cv / 2 + cv / 4) : cv;
        default: ov = sm ? (cv + pv) / 2 : cv;
      endcase
      r[ch*CDEPTH +: CDEPTH] = ov[CDEPTH-1:0];
    end
    return r;
  endfunction

  // One clock: drive, step the DUT, then step the model (output before input).
  task automatic tick(input bit ce_i, input logic [PW-1:0] pix, input bit rl, input bit rf, input bit ce_o, input bit hb);
    i_ce_in = ce_i; i_pixel_in = pix; i_reset_line = rl; i_reset_frame = rf;
    i_ce_out = ce_o; i_hblank = hb;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    if (ce_o) begin
      if (p_valid) begin
        exp_valid = 1'b1;
        exp_pix = apply_mode(p_c, p_p, p_sm, int'(i_mode), int'(i_read_y), m_eff);
      end
      if (hb) begin
        p_valid = 1'b0;
        m_eff = clamp_scale(int'(i_scale));
        m_k = 0;
      end else begin
        int ab, a, hp;
        ab = m_k / m_eff;
        a = (ab > LENGTH - 1) ? LENGTH - 1 : ab;
        hp = m_k % m_eff;
        p_valid = 1'b1;
        p_c = src(a);
        p_sm = (hp == 0) && (a > 0);
        p_p = p_sm ? src((ab - 1 > LENGTH - 1) ? LENGTH - 1 : ab - 1) : '0;
        m_k++;
      end
    end
    if (ce_i) begin
      bit lf, ff;
      lf = m_rl_prev && !rl;
      ff = m_rf_prev && !rf;
      if (lf) begin
        m_width = m_cur.size();
        for (int i = 0; i < m_width; i++) m_line[i] = m_cur[i];
        m_cur.delete();
        m_valid = 1'b1;
      end else if (m_cur.size() < LENGTH) begin
        m_cur.push_back(pix);
      end else if (!ff) begin
        m_ovf = 1'b1;
      end
      if (ff) m_ovf = 1'b0;
      m_rl_prev = rl;
      m_rf_prev = rf;
    end
    i_ce_in = 1'b0; i_ce_out = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_ce_in = 1'b0; i_ce_out = 1'b0;
    i_reset_line = 1'b0; i_reset_frame = 1'b0; i_hblank = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    m_cur.delete(); m_width = 0; m_valid = 1'b0; m_ovf = 1'b0;
    m_rl_prev = 1'b0; m_rf_prev = 1'b0; m_eff = 1; m_k = 0; p_valid = 1'b0;
  endtask

  // Active pixels, one blank pixel, then the line falling edge that swaps.
  task automatic load_line(input logic [PW-1:0] px[$]);
    foreach (px[i]) tick(1'b1, px[i], 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic blank_out(input int n);
    for (int b = 0; b < n; b++) tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_pixel_out !== '0) begin n_errors++; $display("FAIL reset_pixel got %h expected 0", o_pixel_out); end
    n_checks++;
    if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b expected 0", o_overflow); end
  endtask

  task automatic test_no_line();
    for (int s = 0; s < 8; s++) begin
      i_scale = 3'(s); i_mode = 2'(s % 4); i_read_y = YW'(s);
      blank_out(3);
      for (int j = 0; j <= 40; j++) begin
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (exp_valid) begin
          n_checks++;
          if (o_pixel_out !== exp_pix || o_pixel_out !== '0) begin
            n_errors++; $display("FAIL no_line s=%0d k=%0d got %h expected %h", s, j - 1, o_pixel_out, exp_pix);
          end
        end
      end
    end
  endtask

  task automatic test_nearest_x2();
    logic [PW-1:0] px[$];
    for (int i = 1; i <= 8; i++) px.push_back(PW'(i));
    load_line(px);
    i_scale = 3'd2; i_mode = 2'd0; i_read_y = '0;
    blank_out(3);
    for (int j = 0; j <= 22; j++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (exp_valid) begin
        n_checks++;
        if (o_pixel_out !== exp_pix) begin
          n_errors++; $display("FAIL nearest_x2 k=%0d got %h expected %h", j - 1, o_pixel_out, exp_pix);
        end
      end
    end
  endtask

  task automatic test_scanline();
    logic [PW-1:0] px[$];
    for (int i = 0; i < 8; i++) px.push_back({8'(8'h80 + i), 8'(8'h41 + 3 * i), 8'(8'h10 * (i + 1))});
    load_line(px);
    i_scale = 3'd3;
    for (int v = 0; v < 4; v++) begin
      i_mode = (v < 2) ? 2'd1 : 2'd2;
      i_read_y = (v % 2 == 0) ? YW'(2) : YW'(0);
      blank_out(3);
      for (int j = 0; j <= 27; j++) begin
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (exp_valid) begin
          n_checks++;
          if (o_pixel_out !== exp_pix) begin
            n_errors++; $display("FAIL scanline v=%0d k=%0d got %h expected %h", v, j - 1, o_pixel_out, exp_pix);
          end
        end
      end
    end
  endtask

  task automatic test_smooth();
    logic [PW-1:0] px[$];
    px.push_back(24'h000020); px.push_back(24'h000040);
    load_line(px);
    i_mode = 2'd3; i_read_y = '0;
    for (int s = 2; s >= 1; s--) begin
      i_scale = 3'(s);
      blank_out(3);
      for (int j = 0; j <= 9; j++) begin
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (exp_valid) begin
          n_checks++;
          if (o_pixel_out !== exp_pix) begin
            n_errors++; $display("FAIL smooth s=%0d k=%0d got %h expected %h", s, j - 1, o_pixel_out, exp_pix);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] px[$];
    for (int i = 0; i < LENGTH + 5; i++) px.push_back(PW'($urandom));
    load_line(px);
    n_checks++;
    if (o_overflow !== m_ovf || o_overflow !== 1'b1) begin
      n_errors++; $display("FAIL overflow_set got %b expected %b", o_overflow, m_ovf);
    end
    i_scale = 3'd1; i_mode = 2'd0; i_read_y = '0;
    blank_out(3);
    for (int j = 0; j <= LENGTH + 6; j++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (exp_valid) begin
        n_checks++;
        if (o_pixel_out !== exp_pix) begin
          n_errors++; $display("FAIL overflow_replay k=%0d got %h expected %h", j - 1, o_pixel_out, exp_pix);
        end
      end
    end
    tick(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_hold got %b expected 1", o_overflow); end
    tick(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (o_overflow !== m_ovf || o_overflow !== 1'b0) begin
      n_errors++; $display("FAIL overflow_clear got %b expected %b", o_overflow, m_ovf);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [PW-1:0] px[$];
      int len, n;
      len = $urandom_range(LENGTH - 2, 1);
      for (int i = 0; i < len; i++) px.push_back(PW'($urandom));
      load_line(px);
      i_scale = 3'($urandom_range(7, 0));
      i_mode = 2'($urandom_range(3, 0));
      i_read_y = YW'($urandom_range(SCALE_MAX - 1, 0));
      n = (len + 3) * clamp_scale(int'(i_scale));
      if (n > 200) n = 200;
      blank_out(3);
      for (int j = 0; j <= n; j++) begin
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (exp_valid) begin
          n_checks++;
          if (o_pixel_out !== exp_pix) begin
            n_errors++; $display("FAIL random it=%0d k=%0d got %h expected %h", it, j - 1, o_pixel_out, exp_pix);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    i_scale = 3'd2; i_mode = 2'd0; i_read_y = '0;
    for (int b = 0; b < 3; b++) tick(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    for (int ln = 0; ln < 2; ln++) begin
      for (int j = 0; j <= 40; j++) begin
        if (j == 15) i_scale = 3'd4;
        tick(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        if (exp_valid) begin
          n_checks++;
          if (o_pixel_out !== exp_pix) begin
            n_errors++; $display("FAIL back_to_back line=%0d k=%0d got %h expected %h", ln, j - 1, o_pixel_out, exp_pix);
          end
        end
      end
      tick(1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int b = 0; b < 3; b++) tick(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_midline();
    i_scale = 3'd2; i_mode = 2'd0;
    blank_out(3);
    for (int j = 0; j < 5; j++) tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    n_checks++;
    if (o_pixel_out !== '0) begin n_errors++; $display("FAIL midline_reset_pixel got %h expected 0", o_pixel_out); end
    blank_out(3);
    for (int j = 0; j <= 20; j++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (exp_valid) begin
        n_checks++;
        if (o_pixel_out !== exp_pix || o_pixel_out !== '0) begin
          n_errors++; $display("FAIL midline_black k=%0d got %h expected %h", j - 1, o_pixel_out, exp_pix);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_line();
    test_nearest_x2();
    test_scanline();
    test_smooth();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
